gf_mult_scheduler: RTL
======================

// Module: gf_mult_scheduler
// PURPOSE
//  Shares one 192-bit GF(p) multiplier (Multiplication_192x192) among NUM_REQ requesters.
//  Requesters are ECDH point-add/point-double sequencers; arbitration is round-robin.
//  - Latches the winner's operands and fires the multiplier's one-cycle start.
//  - Holds the operands stable for the whole run.
//  - Returns the reduced product to the winning requester, tagged with its id.
//  - A watchdog bounds the wait for a result.
// PARAMETERS
//  NUM_REQ   4       number of requesters (2..8)
//  BW_GF     `BW_GF  field element width (192)
//  MIN_LAT   12      earliest legal result cycle after start (= BW_GF/16 partial-product cycles)
//  TIMEOUT   64      BUSY cycles before the job is aborted with error
// PORTS
//  clk         in   1               clock, rising edge
//  rst_n       in   1               asynchronous active-low reset
//  req_valid   in   NUM_REQ         per-requester job request, level, held until ready
//  req_ready   out  NUM_REQ         one-hot grant; handshake = valid & ready
//  req_a       in   NUM_REQ*BW_GF   operand A, slice i for requester i
//  req_b       in   NUM_REQ*BW_GF   operand B, slice i
//  resp_valid  out  NUM_REQ         one-cycle result pulse to the owning requester
//  resp_data   out  BW_GF           shared result bus, valid with resp_valid
//  resp_err    out  1               qualifies resp_valid: job timed out, resp_data = 0
//  busy        out  1               high in any state other than IDLE
//  mult_start  out  1               to multiplier rst (sync start), one-cycle pulse
//  mult_a      out  BW_GF           to multiplier a
//  mult_b      out  BW_GF           to multiplier b
//  mult_out    in   BW_GF           from multiplier out
//  mult_valid  in   1               from multiplier valid (one-cycle pulse)
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; rr pointer=NUM_REQ-1, so requester 0 has priority first.
//  FSM states: IDLE -> START -> BUSY -> DONE -> IDLE.
//  - IDLE: req_ready = rr pick among req_valid, starting at ptr+1 mod NUM_REQ (combinational).
//    On handshake: latch A/B, latch id; ptr<=id; go START. No request: stay, req_ready=0.
//  - START: mult_start=1 for exactly this cycle; mult_a/mult_b already hold the latched operands.
//    Clear wait counter; go BUSY.
//  - BUSY: wait counter increments every cycle (saturating, 7 bits).
//    mult_valid with counter >= MIN_LAT-1: capture mult_out, err=0, go DONE.
//    mult_valid earlier than that is stale (a leftover from an aborted job); ignore it, stay BUSY.
//    counter == TIMEOUT-1 without an accepted valid: err=1, data=0, go DONE.
//  - DONE: resp_valid[id]=1, resp_data, resp_err for one cycle; go IDLE. Requesters cannot backpressure.
//  - mult_a/mult_b change only on the IDLE handshake. They stay constant from START through DONE,
//    because the multiplier slices b every cycle.
//  - mult_valid outside BUSY: ignored, no state change.
//  Latency: handshake at T; mult_start at T+1; result at V yields resp_valid at V+1.
//    Next grant possible at V+2.
//  Fairness: a requester holding req_valid waits at most NUM_REQ-1 jobs.
//  Simultaneous events:
//    - req_valid dropping in the same IDLE cycle as a pick: no handshake, ptr unchanged.
//    - Valid and timeout in the same cycle: valid wins, err=0.
//  Reset mid-job: async return to IDLE, outputs 0, no response issued.
//    The multiplier may still emit a late valid; the MIN_LAT guard discards it on the next job.
// STRUCTURE
//  Shared ecdh defines file holds:
//    - `BW_GF`
//    - FSM state localparams: IDLE=2'd0, START=2'd1, BUSY=2'd2, DONE=2'd3
//  Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs onehot gnt[N], gnt_id[$clog2(N)], any.
//    Purely combinational, reused by other shared ECDH resources.
//  Top level: FSM, operand/id/result registers, wait counter, output decode.
//  The multiplier is instantiated outside this block.
// TESTING
//  Bench uses a multiplier model with programmable latency.
//  1. Single job: req_valid=4'b0001, a=3, b=5, latency 16.
//     -> mult_start 1 cycle after handshake; resp_valid=4'b0001 and resp_data=15 one cycle after mult_valid; err=0.
//  2. All four requesting continuously, 8 jobs -> grant order 0,1,2,3,0,1,2,3; each resp_valid goes only to its owner.
//  3. Operand stability: req_a/req_b of the winner changed during BUSY -> mult_a/mult_b unchanged until DONE;
//     result uses the latched values.
//  4. Stale valid: mult_valid at cycle 3 after start, then at 16 -> first ignored, response from the second.
//  5. Timeout: model never asserts valid -> resp_valid with resp_err=1, resp_data=0 at BUSY cycle 64; then IDLE.
//  6. rst_n low at BUSY cycle 5, release, new job -> no response for the aborted job; the new job completes
//     normally; ptr restarts at requester 0.

Source files
------------

// File: rtl/gf_mult_scheduler_pkg.sv
// Shared types and constants for the GF(p) multiplier scheduler and its arbiter.
package gf_mult_scheduler_pkg;

  localparam int unsigned GF_BW = 192;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/gf_mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps modulo N.
module rr_arbiter
  import gf_mult_scheduler_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = W'((32'(ptr) + k) % N);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf_mult_scheduler.sv
// Shares one GF(p) multiplier among NUM_REQ requesters: round-robin grant,
// operand latch, start pulse, guarded result capture and watchdog abort.
module gf_mult_scheduler
  import gf_mult_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BW_GF   = GF_BW,
  parameter int unsigned MIN_LAT = 12,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*BW_GF-1:0] req_a,
  input  logic [NUM_REQ*BW_GF-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [BW_GF-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     mult_start,
  output logic [BW_GF-1:0]         mult_a,
  output logic [BW_GF-1:0]         mult_b,
  input  logic [BW_GF-1:0]         mult_out,
  input  logic                     mult_valid
);

  localparam int unsigned      IDW        = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(MIN_LAT - 1);
  localparam logic [CNT_W-1:0] ABORT_CNT  = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     id;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               any;
  logic               handshake;
  logic [BW_GF-1:0]   sel_a;
  logic [BW_GF-1:0]   sel_b;

  rr_arbiter #(
    .N (NUM_REQ),
    .W (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign handshake = (state == IDLE) && any;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*BW_GF +: BW_GF];
        sel_b = req_b[i*BW_GF +: BW_GF];
      end
    end
  end

  // Response outputs are single-cycle: cleared every cycle unless entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IDW'(NUM_REQ - 1);
      id         <= '0;
      cnt        <= '0;
      mult_start <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            mult_a     <= sel_a;
            mult_b     <= sel_b;
            id         <= gnt_id;
            ptr        <= gnt_id;
            mult_start <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          // Valids before ACCEPT_CNT belong to an aborted job; a valid beats the timeout.
          if (mult_valid && (cnt >= ACCEPT_CNT)) begin
            resp_valid <= NUM_REQ'(1) << id;
            resp_data  <= mult_out;
            state      <= DONE;
          end else if (cnt == ABORT_CNT) begin
            resp_valid <= NUM_REQ'(1) << id;
            resp_err   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
